prog_mem_ctrl: RTL and testbench

Program-memory controller for the 8-bit microcontroller: owns the 256×8 unified program/data RAM and the program counter. It sits directly upstream of the control unit and supplies the byte the control unit samples as `mem_read_data` during fetch and LOAD. It applies the control unit's `pc_inc`, `pc_load`/`pc_next` and STORE writes. After reset it runs a boot phase that streams a program into RAM over a valid/ready byte interface, then releases the CPU.

---
 rtl/uc_pkg.sv | 20 ++
 rtl/prog_mem_ctrl_if.sv | 35 +++
 rtl/ram_256x8.sv | 23 ++
 rtl/prog_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_prog_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the 8-bit microcontroller: bus widths, the program-memory
// controller state encoding and the boot checksum rule.
package uc_pkg;

    localparam int UC_ADDR_W = 8;
    localparam int UC_DATA_W = 8;

    typedef enum logic [1:0] {
        PMC_BOOT  = 2'd0,
        PMC_RUN   = 2'd1,
        PMC_ERROR = 2'd2
    } pmc_state_t;

    // A boot image is good when the byte sum plus the trailing checksum wraps to zero.
    function automatic logic checksum_ok(logic [UC_DATA_W-1:0] acc,
                                         logic [UC_DATA_W-1:0] csum);
        return (UC_DATA_W'(acc + csum) == '0);
    endfunction

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// Boot-stream and CPU-side bus of the program-memory controller.
// The slave modport is the controller; the master modport is the boot source plus control unit.
interface prog_mem_ctrl_if;
    import uc_pkg::*;

    logic                 boot_valid;
    logic [UC_DATA_W-1:0] boot_data;
    logic                 boot_last;
    logic                 boot_ready;
    logic                 pc_inc;
    logic                 pc_load;
    logic [UC_ADDR_W-1:0] pc_next;
    logic                 data_sel;
    logic [UC_ADDR_W-1:0] mem_addr;
    logic                 mem_write_en;
    logic [UC_DATA_W-1:0] mem_write_data;
    logic [UC_DATA_W-1:0] mem_read_data;
    logic [UC_ADDR_W-1:0] pc;
    logic                 cpu_run;
    logic                 boot_done;
    logic                 boot_err;

    modport slave (
        input  boot_valid, boot_data, boot_last, pc_inc, pc_load, pc_next,
               data_sel, mem_addr, mem_write_en, mem_write_data,
        output boot_ready, mem_read_data, pc, cpu_run, boot_done, boot_err
    );

    modport master (
        output boot_valid, boot_data, boot_last, pc_inc, pc_load, pc_next,
               data_sel, mem_addr, mem_write_en, mem_write_data,
        input  boot_ready, mem_read_data, pc, cpu_run, boot_done, boot_err
    );

endinterface

// File: rtl/ram_256x8.sv
// 256x8 unified program/data RAM: synchronous write, asynchronous read, no reset.
module ram_256x8
    import uc_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [UC_ADDR_W-1:0] waddr,
    input  logic [UC_DATA_W-1:0] wdata,
    input  logic [UC_ADDR_W-1:0] raddr,
    output logic [UC_DATA_W-1:0] rdata
);

    logic [UC_DATA_W-1:0] mem [2**UC_ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-memory controller: boots a byte stream into RAM, then owns PC and CPU RAM access.
// Define PROG_MEM_CHECKSUM_EN to treat the boot_last byte as a checksum with an ERROR state.
module prog_mem_ctrl
    import uc_pkg::*;
#(
    parameter logic [UC_ADDR_W-1:0] RESET_VECTOR   = 8'h00,
    parameter int                   MAX_BOOT_BYTES = 256
) (
    input  logic            clk,
    input  logic            rst,
    prog_mem_ctrl_if.slave  bus
);

    localparam logic [UC_ADDR_W-1:0] LAST_PTR = UC_ADDR_W'(MAX_BOOT_BYTES - 1);

    pmc_state_t           state, state_nx;
    logic [UC_ADDR_W-1:0] load_ptr;
    logic [UC_ADDR_W-1:0] pc_r;
    logic                 xfer, boot_end, store;
    logic                 ready, run, err;
    logic                 ram_we;
    logic [UC_ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [UC_DATA_W-1:0] ram_wdata, ram_rdata;

    assign xfer = bus.boot_valid && (state == PMC_BOOT);
    // load_ptr equals the count of stored bytes, so it also detects the byte limit.
    assign boot_end = xfer && (bus.boot_last || (load_ptr == LAST_PTR));

`ifdef PROG_MEM_CHECKSUM_EN
    logic [UC_DATA_W-1:0] acc;

    assign store = xfer && !bus.boot_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (store) begin
            acc <= acc + bus.boot_data;
        end
    end
`else
    assign store = xfer;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PMC_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        run      = 1'b0;
        err      = 1'b0;
        case (state)
            PMC_BOOT: begin
                ready = 1'b1;
                if (boot_end) begin
`ifdef PROG_MEM_CHECKSUM_EN
                    if (bus.boot_last && !checksum_ok(acc, bus.boot_data)) begin
                        state_nx = PMC_ERROR;
                    end else begin
                        state_nx = PMC_RUN;
                    end
`else
                    state_nx = PMC_RUN;
`endif
                end
            end
            PMC_RUN: begin
                run = 1'b1;
            end
            PMC_ERROR: begin
`ifdef PROG_MEM_CHECKSUM_EN
                err = 1'b1;
`endif
            end
            default: begin
                state_nx = PMC_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ptr <= '0;
        end else if (store) begin
            load_ptr <= load_ptr + 1'b1;
        end
    end

    // PC is frozen at the reset vector until RUN, so entering RUN needs no explicit reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_VECTOR;
        end else if (run) begin
            if (bus.pc_load) begin
                pc_r <= bus.pc_next;
            end else if (bus.pc_inc) begin
                pc_r <= pc_r + 1'b1;
            end
        end
    end

    always_comb begin
        ram_we    = store;
        ram_waddr = load_ptr;
        ram_wdata = bus.boot_data;
        if (run) begin
            ram_we    = bus.mem_write_en;
            ram_waddr = bus.mem_addr;
            ram_wdata = bus.mem_write_data;
        end
    end

    assign ram_raddr = bus.data_sel ? bus.mem_addr : pc_r;

    ram_256x8 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.mem_read_data = run ? ram_rdata : '0;
    assign bus.pc            = pc_r;
    assign bus.boot_ready    = ready;
    assign bus.cpu_run       = run;
    assign bus.boot_done     = run;
    assign bus.boot_err      = err;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Bench for prog_mem_ctrl: directed boot/PC/store scenarios plus randomized rounds,
// all outputs compared every cycle against a byte-level model of the controller.
module tb_prog_mem_ctrl;

    localparam int          MAXB = 8;
    localparam logic [7:0]  RV   = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_ctrl_if bif();

    prog_mem_ctrl #(.RESET_VECTOR(RV), .MAX_BOOT_BYTES(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: boot progress as a byte count, RAM as an array with known flags.
    logic [7:0] m_ram [256];
    bit         m_known [256];
    bit         m_run, m_err;
    int         m_cnt;
    logic [7:0] m_sum;
    logic [7:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        m_sum = 8'h00;
        m_pc  = RV;
    endtask

    task automatic model_store(input logic [7:0] d);
        m_ram[m_cnt % 256]   = d;
        m_known[m_cnt % 256] = 1'b1;
        m_sum = 8'(m_sum + d);
        m_cnt++;
    endtask

    task automatic model_edge();
        if (!m_run && !m_err) begin
            if (bif.boot_valid) begin
`ifdef PROG_MEM_CHECKSUM_EN
                if (bif.boot_last) begin
                    if (8'(m_sum + bif.boot_data) == 8'h00) m_run = 1'b1;
                    else                                    m_err = 1'b1;
                end else begin
                    model_store(bif.boot_data);
                    if (m_cnt == MAXB) m_run = 1'b1;
                end
`else
                model_store(bif.boot_data);
                if (bif.boot_last || m_cnt == MAXB) m_run = 1'b1;
`endif
            end
        end else if (m_run) begin
            if (bif.mem_write_en) begin
                m_ram[bif.mem_addr]   = bif.mem_write_data;
                m_known[bif.mem_addr] = 1'b1;
            end
            if (bif.pc_load)     m_pc = bif.pc_next;
            else if (bif.pc_inc) m_pc = 8'(m_pc + 8'd1);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] a;
        a = bif.data_sel ? bif.mem_addr : m_pc;
        chk("boot_ready", bif.boot_ready, !m_run && !m_err);
        chk("cpu_run",    bif.cpu_run,    m_run);
        chk("boot_done",  bif.boot_done,  m_run);
        chk("boot_err",   bif.boot_err,   m_err);
        chk("pc",         bif.pc,         m_pc);
        if (!m_run)          chk("rd_idle", bif.mem_read_data, 8'h00);
        else if (m_known[a]) chk("rd",      bif.mem_read_data, m_ram[a]);
    endtask

    task automatic tick();
        #4;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bif.boot_valid     = 1'b0;
        bif.boot_data      = 8'h00;
        bif.boot_last      = 1'b0;
        bif.pc_inc         = 1'b0;
        bif.pc_load        = 1'b0;
        bif.pc_next        = 8'h00;
        bif.data_sel       = 1'b0;
        bif.mem_addr       = 8'h00;
        bif.mem_write_en   = 1'b0;
        bif.mem_write_data = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bif.boot_valid = 1'b1;
        bif.boot_data  = d;
        bif.boot_last  = last;
        tick();
        bif.boot_valid = 1'b0;
        bif.boot_last  = 1'b0;
    endtask

    task automatic boot_good();
`ifdef PROG_MEM_CHECKSUM_EN
        send(8'h0A, 1'b0);
        send(8'h12, 1'b0);
        send(8'hE4, 1'b1);
`else
        send(8'h0A, 1'b0);
        send(8'h12, 1'b0);
        send(8'hA0, 1'b0);
        send(8'h05, 1'b1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        idle();
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        model_reset();
        do_reset();

        // Boot load, then fetch and data reads
        boot_good();
        #1;
        chk("t1_cpu_run", bif.cpu_run, 1'b1);
        chk("t1_fetch0", bif.mem_read_data, 8'h0A);
        bif.data_sel = 1'b1;
        bif.mem_addr = 8'h01;
        #1;
        chk("t1_ram1", bif.mem_read_data, 8'h12);
        idle();

        // PC priority and wrap
        bif.pc_inc = 1'b1; bif.pc_load = 1'b1; bif.pc_next = 8'h40;
        tick();
        #1;
        chk("t2_load_prio", bif.pc, 8'h40);
        bif.pc_inc = 1'b0; bif.pc_next = 8'hFF;
        tick();
        bif.pc_load = 1'b0; bif.pc_inc = 1'b1;
        tick();
        #1;
        chk("t2_wrap", bif.pc, 8'h00);
        idle();

        // STORE then LOAD in RUN
        bif.mem_write_en = 1'b1; bif.mem_addr = 8'h80; bif.mem_write_data = 8'h5A;
        bif.data_sel = 1'b1;
        tick();
        bif.mem_write_en = 1'b0;
        #1;
        chk("t3_load", bif.mem_read_data, 8'h5A);
        bif.mem_write_en = 1'b1; bif.mem_addr = 8'h08; bif.mem_write_data = 8'hC3;
        tick();
        idle();

        // Writes and pc_inc during BOOT are ignored
        do_reset();
        bif.mem_write_en = 1'b1; bif.mem_addr = 8'h80; bif.mem_write_data = 8'h33;
        bif.pc_inc = 1'b1;
        tick();
        tick();
        boot_good();
        idle();
        bif.data_sel = 1'b1; bif.mem_addr = 8'h80;
        #1;
        chk("t4_boot_store", bif.mem_read_data, 8'h5A);
        chk("t4_pc", bif.pc, RV);
        idle();

        // Byte limit ends boot without boot_last
        do_reset();
        for (int i = 0; i < MAXB; i++) send(8'(i * 17 + 3), 1'b0);
        #1;
        chk("t5_limit_run", bif.cpu_run, 1'b1);
        bif.boot_valid = 1'b1; bif.boot_data = 8'h99;
        #1;
        chk("t5_ready_low", bif.boot_ready, 1'b0);
        tick();
        idle();
        bif.data_sel = 1'b1; bif.mem_addr = 8'h08;
        #1;
        chk("t5_ninth_ign", bif.mem_read_data, 8'hC3);
        idle();

        // Reset in the middle of boot restarts at address 0
        do_reset();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        do_reset();
`ifdef PROG_MEM_CHECKSUM_EN
        send(8'hEE, 1'b0);
        send(8'h12, 1'b1);
`else
        send(8'hEE, 1'b1);
`endif
        bif.data_sel = 1'b1; bif.mem_addr = 8'h00;
        #1;
        chk("t6_ram0", bif.mem_read_data, 8'hEE);
        chk("t6_pc", bif.pc, RV);
        idle();

`ifdef PROG_MEM_CHECKSUM_EN
        // Bad checksum locks into ERROR
        do_reset();
        send(8'h01, 1'b0);
        send(8'h00, 1'b1);
        #1;
        chk("t7_err", bif.boot_err, 1'b1);
        chk("t7_run", bif.cpu_run, 1'b0);
        bif.pc_inc = 1'b1;
        tick();
        tick();
        #1;
        chk("t7_pc_hold", bif.pc, RV);
        idle();
`endif

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            do_reset();
            cyc = 0;
            while (!m_run && !m_err && cyc < 40) begin
                bif.pc_inc         = 1'($urandom_range(0, 1));
                bif.mem_write_en   = 1'($urandom_range(0, 1));
                bif.mem_addr       = 8'($urandom_range(0, 15));
                bif.mem_write_data = 8'($urandom);
                bif.data_sel       = 1'($urandom_range(0, 1));
                bif.boot_valid     = ($urandom_range(0, 3) != 0) || (cyc == 39);
                bif.boot_data      = 8'($urandom);
                bif.boot_last      = ($urandom_range(0, 5) == 0) || (cyc == 39);
`ifdef PROG_MEM_CHECKSUM_EN
                if (bif.boot_last && $urandom_range(0, 1) == 1) bif.boot_data = 8'(8'h00 - m_sum);
`endif
                tick();
                cyc++;
            end
            for (int k = 0; k < 60; k++) begin
                bif.pc_load        = ($urandom_range(0, 7) == 0);
                bif.pc_inc         = 1'($urandom_range(0, 1));
                bif.pc_next        = 8'($urandom_range(0, 15));
                bif.mem_write_en   = ($urandom_range(0, 3) == 0);
                bif.mem_addr       = 8'($urandom_range(0, 15));
                bif.mem_write_data = 8'($urandom);
                bif.data_sel       = 1'($urandom_range(0, 1));
                bif.boot_valid     = 1'($urandom_range(0, 1));
                bif.boot_data      = 8'($urandom);
                bif.boot_last      = 1'($urandom_range(0, 1));
                tick();
            end
            idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
